// File: rtl/gray_ptr_sync_g2b.sv
// Gray pointer synchroniser + Gray-to-binary conversion with change/delta/integrity tracking.
// Latency: SYNC_STAGES+1 clk edges from gray_in sample to bin_out/gray_out.
// Backpressure: none; outputs update every cycle. Optional check: GRAY_ERR_CHECK_EN.
module gray_ptr_sync_g2b #(
    parameter int PTR_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int WARMUP      = SYNC_STAGES + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W-1:0] gray_in,
    output logic [PTR_W-1:0] bin_out,
    output logic [PTR_W-1:0] gray_out,
    output logic             changed,
    output logic [PTR_W-1:0] delta,
    output logic             err,
    input  logic             err_clr
);

    localparam int CNT_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] gs;
    logic [PTR_W-1:0] bin_d;
    logic [PTR_W-1:0] gray_q, bin_q, delta_q, delta_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] warm_q, warm_d;
    logic             warm_done;
    logic [PTR_W-1:0] gray_diff;
    logic             moved;

    // Plain flop chain: no logic between stages so each stage can resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d            = '0;
        bin_d[PTR_W-1]   = gs[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) bin_d[i] = bin_d[i+1] ^ gs[i];
    end

    // Change tracking against the previous registered Gray value; silent during warm-up.
    always_comb begin
        warm_done = (warm_q >= WARMUP_C);
        warm_d    = warm_done ? warm_q : warm_q + 1'b1;
        gray_diff = gs ^ gray_q;
        moved     = |gray_diff;
        changed_d = warm_done && moved;
        delta_d   = changed_d ? (bin_d - bin_q) : '0;
    end

    // Registered outputs and warm-up counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q    <= '0;
            bin_q     <= '0;
            changed_q <= 1'b0;
            delta_q   <= '0;
            warm_q    <= '0;
        end else begin
            gray_q    <= gs;
            bin_q     <= bin_d;
            changed_q <= changed_d;
            delta_q   <= delta_d;
            warm_q    <= warm_d;
        end
    end

`ifdef GRAY_ERR_CHECK_EN
    logic multi_bit;
    logic err_q, err_d;

    // More than one bit set in the diff <=> clearing the lowest set bit leaves something.
    always_comb begin
        multi_bit = |(gray_diff & (gray_diff - 1'b1));
        err_d     = err_q;
        if (err_clr)                err_d = 1'b0;
        if (warm_done && multi_bit) err_d = 1'b1;
    end

    // Sticky error flag; a fresh detection beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign changed  = changed_q;
    assign delta    = delta_q;

endmodule

// File: tb/tb_gray_ptr_sync_g2b.sv
module tb_gray_ptr_sync_g2b;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic [W-1:0] bin_out, gray_out, delta;
    logic         changed, err, err_clr;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef GRAY_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    gray_ptr_sync_g2b #(.PTR_W(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .changed  (changed),
        .delta    (delta),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".bin"},   32'(bin_out),  0);
        chk({tag, ".gray"},  32'(gray_out), 0);
        chk({tag, ".chg"},   32'(changed),  0);
        chk({tag, ".delta"}, 32'(delta),    0);
        chk({tag, ".err"},   32'(err),      0);
    endtask

    // Apply a Gray value at a negedge and check latency, arrival and one-cycle pulse.
    task automatic step(input string tag, input logic [W-1:0] g, input logic [W-1:0] old_b,
                        input logic [W-1:0] new_b, input logic [W-1:0] exp_d);
        gray_in = g;
        tick(2);
        chk({tag, ".lat"}, 32'(bin_out), 32'(old_b));
        tick(1);
        chk({tag, ".bin"},   32'(bin_out),  32'(new_b));
        chk({tag, ".gray"},  32'(gray_out), 32'(g));
        chk({tag, ".chg"},   32'(changed),  1);
        chk({tag, ".delta"}, 32'(delta),    32'(exp_d));
        tick(1);
        chk({tag, ".pulse"}, 32'(changed),  0);
        chk({tag, ".d0"},    32'(delta),    0);
    endtask

    initial begin
        rst_n   = 1'b0;
        gray_in = '0;
        err_clr = 1'b0;
        #1;
        chk_all_zero("rst");
        tick(2);
        rst_n = 1'b1;

        // Idle at zero through and past warm-up.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle.bin", 32'(bin_out), 0);
            chk("idle.chg", 32'(changed), 0);
            chk("idle.err", 32'(err),     0);
        end

        // Legal single-bit walk 0 -> 1 -> 2 -> 3.
        step("s1", 6'b000001, 6'd0, 6'd1, 6'd1);
        step("s2", 6'b000011, 6'd1, 6'd2, 6'd1);
        step("s3", 6'b000010, 6'd2, 6'd3, 6'd1);

        // Reset mid-run clears outputs immediately, without a clock edge.
        gray_in = 6'b100000;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick(1);
        rst_n = 1'b1;
        tick(10);
        chk("wrap.pre", 32'(bin_out), 63);
        chk("wrap.pre.err", 32'(err), 0);

        // Wrap 63 -> 0 is a legal single-bit change with delta 1.
        step("wrap", 6'b000000, 6'd63, 6'd0, 6'd1);
        chk("wrap.err", 32'(err), 0);

        // Illegal two-bit jump 0 -> 3 (binary 2).
        step("ill", 6'b000011, 6'd0, 6'd2, 6'd2);
        chk("ill.err", 32'(err), 32'(ERR_EXP));
        tick(3);
        chk("ill.hold", 32'(err), 32'(ERR_EXP));

        // Clear alone.
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr.err", 32'(err), 0);

        // Walk back legally to 0, then repeat the jump with clear in the detect cycle.
        step("b1", 6'b000001, 6'd2, 6'd1, 6'd63);
        step("b0", 6'b000000, 6'd1, 6'd0, 6'd63);
        chk("b0.err", 32'(err), 0);
        gray_in = 6'b000011;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ill2.bin",   32'(bin_out), 2);
        chk("ill2.delta", 32'(delta),   2);
        chk("ill2.err",   32'(err),     32'(ERR_EXP));
        tick(1);
        chk("ill2.hold",  32'(err),     32'(ERR_EXP));

        // Reset with err possibly set, then release with nonzero gray_in inside warm-up.
        gray_in = 6'b000101;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst2");
        tick(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("warm.chg", 32'(changed), 0);
            chk("warm.err", 32'(err),     0);
            if (i == 2) chk("warm.lat", 32'(bin_out), 0);
            if (i >= 3) begin
                chk("warm.bin",  32'(bin_out),  6);
                chk("warm.gray", 32'(gray_out), 5);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
